ssd1306_stream_seq: RTL and testbench

- Byte-level sequencer directly upstream of the I2C byte master; drives its data/start/last inputs and consumes its busy/done.
- On request, emits the SSD1306 power-up command sequence, or a full frame (address-window commands plus 1024 framebuffer bytes) read from the display framebuffer.
- Each I2C transaction is built as: slave address byte, control byte, payload; `last` is asserted on the final payload byte.

---
 rtl/ssd1306_stream_seq.sv | 158 +++++++++++++++
 tb/tb_ssd1306_stream_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_stream_seq.sv
// Byte sequencer feeding an I2C byte master: SSD1306 init command stream, or a full
// frame (address-window commands followed by the framebuffer contents).
module ssd1306_stream_seq #(
   parameter logic [6:0] I2C_ADDR = 7'h3C,
   parameter int         FB_BYTES = 1024,
   parameter int         FB_AW    = $clog2(FB_BYTES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init_req,
   input  logic             frame_req,
   output logic [FB_AW-1:0] fb_addr,
   input  logic [7:0]       fb_data,
   output logic [7:0]       i2c_data,
   output logic             i2c_start,
   output logic             i2c_last,
   input  logic             i2c_busy,
   input  logic             i2c_done,
   output logic             busy,
   output logic             init_done,
   output logic             frame_done
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_REQ, S_WAIT} state_t;
   typedef enum logic [1:0] {T_INIT, T_WIN, T_DATA} txn_t;

   state_t           state_q;
   txn_t             txn_q;
   logic [10:0]      k_q;
   logic [FB_AW-1:0] fb_addr_q;
   logic [7:0]       i2c_data_q;
   logic             i2c_start_q, i2c_last_q, busy_q, init_done_q, frame_done_q;

   logic [4:0]  rom_idx;
   logic [10:0] last_k;
   logic [7:0]  tx_byte_d;

   assign rom_idx = 5'(k_q - 11'd2);

   function automatic logic [7:0] init_rom(input logic [4:0] i);
      case (i)
         5'd0:  return 8'hAE;  5'd1:  return 8'hD5;  5'd2:  return 8'h80;
         5'd3:  return 8'hA8;  5'd4:  return 8'h3F;  5'd5:  return 8'hD3;
         5'd6:  return 8'h00;  5'd7:  return 8'h40;  5'd8:  return 8'h8D;
         5'd9:  return 8'h14;  5'd10: return 8'h20;  5'd11: return 8'h00;
         5'd12: return 8'hA1;  5'd13: return 8'hC8;  5'd14: return 8'hDA;
         5'd15: return 8'h12;  5'd16: return 8'h81;  5'd17: return 8'hCF;
         5'd18: return 8'hD9;  5'd19: return 8'hF1;  5'd20: return 8'hDB;
         5'd21: return 8'h40;  5'd22: return 8'hA4;  5'd23: return 8'hA6;
         5'd24: return 8'hAF;
         default: return 8'h00;
      endcase
   endfunction

   // Column range 0..127, page range 0..7
   function automatic logic [7:0] win_rom(input logic [2:0] i);
      case (i)
         3'd2: return 8'h21;  3'd3: return 8'h00;  3'd4: return 8'h7F;
         3'd5: return 8'h22;  3'd6: return 8'h00;  3'd7: return 8'h07;
         default: return 8'h00;
      endcase
   endfunction

   always_comb begin
      last_k = 11'd26;
      case (txn_q)
         T_WIN:   last_k = 11'd7;
         T_DATA:  last_k = 11'(FB_BYTES + 1);
         default: last_k = 11'd26;
      endcase
   end

   always_comb begin
      tx_byte_d = 8'h00;
      if (k_q == 11'd0)      tx_byte_d = {I2C_ADDR, 1'b0};
      else if (k_q == 11'd1) tx_byte_d = (txn_q == T_DATA) ? 8'h40 : 8'h00;
      else begin
         case (txn_q)
            T_INIT:  tx_byte_d = init_rom(rom_idx);
            T_WIN:   tx_byte_d = win_rom(k_q[2:0]);
            default: tx_byte_d = fb_data;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         txn_q        <= T_INIT;
         k_q          <= '0;
         fb_addr_q    <= '0;
         i2c_data_q   <= '0;
         i2c_start_q  <= 1'b0;
         i2c_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         init_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (init_req || frame_req) begin
                  txn_q   <= init_req ? T_INIT : T_WIN;
                  k_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD;
               end
            end
            S_FETCH: state_q <= S_LOAD;
            S_LOAD: begin
               i2c_data_q  <= tx_byte_d;
               i2c_last_q  <= (k_q == last_k);
               i2c_start_q <= 1'b1;
               state_q     <= S_REQ;
            end
            // Master ticks slowly; keep the request up until it reports busy
            S_REQ: begin
               if (i2c_busy) begin
                  i2c_start_q <= 1'b0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i2c_done) begin
                  if (k_q != last_k) begin
                     k_q <= k_q + 11'd1;
                     if (txn_q == T_DATA && k_q >= 11'd1) begin
                        fb_addr_q <= FB_AW'(k_q - 11'd1);
                        state_q   <= S_FETCH;
                     end else begin
                        state_q <= S_LOAD;
                     end
                  end else if (txn_q == T_WIN) begin
                     txn_q   <= T_DATA;
                     k_q     <= '0;
                     state_q <= S_LOAD;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     if (txn_q == T_INIT) init_done_q  <= 1'b1;
                     else                 frame_done_q <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign fb_addr    = fb_addr_q;
   assign i2c_data   = i2c_data_q;
   assign i2c_start  = i2c_start_q;
   assign i2c_last   = i2c_last_q;
   assign busy       = busy_q;
   assign init_done  = init_done_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd1306_stream_seq.sv
// Bench for ssd1306_stream_seq: I2C byte-master model, synchronous framebuffer and a
// byte-stream reference built directly from the transaction definitions.
module tb_ssd1306_stream_seq;
   localparam int FB = 1024;

   logic       clk = 1'b0, rst_n = 1'b1, init_req = 1'b0, frame_req = 1'b0;
   logic [9:0] fb_addr;
   logic [7:0] fb_data, i2c_data;
   logic       i2c_start, i2c_last, busy, init_done, frame_done;
   logic       m_busy = 1'b0, m_done = 1'b0, spur_done = 1'b0;
   wire        i2c_done = m_done | spur_done;

   ssd1306_stream_seq dut (
      .clk(clk), .rst_n(rst_n), .init_req(init_req), .frame_req(frame_req),
      .fb_addr(fb_addr), .fb_data(fb_data), .i2c_data(i2c_data),
      .i2c_start(i2c_start), .i2c_last(i2c_last), .i2c_busy(m_busy),
      .i2c_done(i2c_done), .busy(busy), .init_done(init_done), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   logic [7:0] fb [FB];
   always @(posedge clk) fb_data <= fb[fb_addr];

   // I2C master model: samples start, raises busy after a delay, captures the byte, pulses done
   int         busy_dly = 3, done_dly = 20;
   bit         rnd_dly = 1'b0;
   int         mph = 0, mcnt = 0, stab_bad = 0, start_in_busy = 0;
   logic [7:0] md;
   logic       ml;
   logic [8:0] cap_q[$];
   always @(negedge clk) begin
      m_done = 1'b0;
      if (!rst_n) begin
         mph = 0; m_busy = 1'b0;
      end else begin
         case (mph)
            0: if (i2c_start) begin
                  md = i2c_data; ml = i2c_last; mph = 1;
                  mcnt = rnd_dly ? int'($urandom_range(1, 4)) : busy_dly;
               end
            1: begin
                  if (i2c_start !== 1'b1 || i2c_data !== md || i2c_last !== ml) stab_bad++;
                  mcnt--;
                  if (mcnt <= 0) begin
                     m_busy = 1'b1; cap_q.push_back({ml, md}); mph = 2;
                     mcnt = rnd_dly ? int'($urandom_range(1, 4)) : done_dly;
                  end
               end
            default: begin
                  if (i2c_start) start_in_busy++;
                  if (i2c_last !== ml) stab_bad++;
                  mcnt--;
                  if (mcnt <= 0) begin m_done = 1'b1; m_busy = 1'b0; mph = 0; end
               end
         endcase
      end
   end

   int   fd_cnt = 0, fd_bad = 0;
   logic busy_prev = 1'b0;
   always @(negedge clk) begin
      if (frame_done === 1'b1) begin
         fd_cnt++;
         if (busy !== 1'b0 || busy_prev !== 1'b1) fd_bad++;
      end
      busy_prev = busy;
   end

   int checks = 0, errors = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference byte streams, entries are {last, data}
   logic [7:0] rom [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                            8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                            8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
   logic [7:0] win [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
   logic [8:0] exp_q[$];

   function automatic void model_init();
      exp_q.push_back(9'h078); exp_q.push_back(9'h000);
      for (int i = 0; i < 25; i++) exp_q.push_back({i == 24, rom[i]});
   endfunction

   function automatic void model_frame();
      exp_q.push_back(9'h078); exp_q.push_back(9'h000);
      for (int i = 0; i < 6; i++) exp_q.push_back({i == 5, win[i]});
      exp_q.push_back(9'h078); exp_q.push_back(9'h040);
      for (int i = 0; i < FB; i++) exp_q.push_back({i == FB - 1, fb[i]});
   endfunction

   task automatic cmp_seq(input string nm);
      int bad = 0;
      chk({nm, "_count"}, cap_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
         if (cap_q[i] !== exp_q[i]) bad++;
      chk({nm, "_bytes_bad"}, bad, 0);
   endtask

   task automatic pulse(input logic ir, input logic fr);
      @(negedge clk); init_req = ir; frame_req = fr;
      @(negedge clk); init_req = 1'b0; frame_req = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int cyc = 0;
      while (busy && cyc < 40000) begin @(negedge clk); cyc++; end
      chk({nm, "_finished_in_budget"}, cyc < 40000, 1);
   endtask

   task automatic wait_caps(input string nm, input int n);
      int cyc = 0;
      while (cap_q.size() < n && cyc < 20000) begin @(negedge clk); cyc++; end
      chk({nm, "_reached"}, cap_q.size() >= n, 1);
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_fb_addr"}, fb_addr, 0);
      chk({nm, "_i2c_data"}, i2c_data, 0);
      chk({nm, "_i2c_start"}, i2c_start, 0);
      chk({nm, "_i2c_last"}, i2c_last, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_init_done"}, init_done, 0);
      chk({nm, "_frame_done"}, frame_done, 0);
   endtask

   typedef struct {
      logic ir, fr, rnd, fbr;
      int   exp_n;
      logic exp_id;
      int   exp_fd;
   } vec_t;
   vec_t vt [5];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int fd0;
      logic acc;
      vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 27,   1'b1, 0};
      vt[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1034, 1'b1, 1};
      vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 27,   1'b1, 0};
      vt[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 0,    1'b1, 0};
      vt[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1034, 1'b1, 1};

      #1 rst_n = 1'b0;
      #2 chk_reset_outs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[v]) begin
         for (int i = 0; i < FB; i++) fb[i] = vt[v].fbr ? 8'($urandom) : 8'(i);
         rnd_dly = vt[v].rnd;
         exp_q.delete(); cap_q.delete();
         if (vt[v].ir) model_init();
         else if (vt[v].fr) model_frame();
         fd0 = fd_cnt;
         pulse(vt[v].ir, vt[v].fr);
         acc = busy;
         chk($sformatf("v%0d_busy_after_req", v), acc, vt[v].ir | vt[v].fr);
         wait_idle($sformatf("v%0d", v));
         repeat (3) @(negedge clk);
         cmp_seq($sformatf("v%0d", v));
         chk($sformatf("v%0d_n_bytes", v), cap_q.size(), vt[v].exp_n);
         chk($sformatf("v%0d_init_done", v), init_done, vt[v].exp_id);
         chk($sformatf("v%0d_frame_pulses", v), fd_cnt - fd0, vt[v].exp_fd);
         chk($sformatf("v%0d_busy_end", v), busy, 0);
         if (vt[v].fr && !vt[v].ir) chk($sformatf("v%0d_fb_addr_end", v), fb_addr, FB - 1);
      end

      // Spurious done while idle must not start anything
      cap_q.delete();
      @(negedge clk); spur_done = 1'b1;
      @(negedge clk); spur_done = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_spur_busy", busy, 0);
      chk("idle_spur_start", i2c_start, 0);
      chk("idle_spur_caps", cap_q.size(), 0);

      // frame_req during INIT is dropped
      rnd_dly = 1'b0; fd0 = fd_cnt;
      exp_q.delete(); cap_q.delete(); model_init();
      pulse(1'b1, 1'b0);
      wait_caps("midinit", 5);
      pulse(1'b0, 1'b1);
      wait_idle("midinit");
      repeat (3) @(negedge clk);
      cmp_seq("midinit");
      chk("midinit_frame_pulses", fd_cnt - fd0, 0);

      // Very slow master: request held 500 cycles, with a spurious done while requesting
      busy_dly = 500;
      exp_q.delete(); cap_q.delete(); model_init();
      pulse(1'b1, 1'b0);
      repeat (100) @(negedge clk);
      spur_done = 1'b1; @(negedge clk); spur_done = 1'b0;
      chk("slow_start_held", i2c_start, 1);
      chk("slow_data_held", i2c_data, 8'h78);
      wait_caps("slow_first", 1);
      busy_dly = 3;
      wait_idle("slow");
      repeat (3) @(negedge clk);
      cmp_seq("slow");

      // Asynchronous reset in the middle of the DATA payload, then a clean restart
      rnd_dly = 1'b1;
      cap_q.delete();
      pulse(1'b0, 1'b1);
      wait_caps("mid_data", 310);
      chk("pre_reset_init_done", init_done, 1);
      #2 rst_n = 1'b0;
      #1 chk_reset_outs("async_reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete(); cap_q.delete(); model_init();
      pulse(1'b1, 1'b0);
      wait_idle("restart");
      repeat (3) @(negedge clk);
      cmp_seq("restart");
      chk("restart_init_done", init_done, 1);

      chk("handshake_stable_violations", stab_bad, 0);
      chk("start_while_busy_violations", start_in_busy, 0);
      chk("frame_done_shape_violations", fd_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
